custom_axi_ip_regs: RTL and testbench

AXI4-Lite slave register front-end that sits directly upstream of the custom_axi_ip core. It converts CPU register writes into the core's din/enable_in stimulus and captures the core's dout, enable_out and status_out into readable registers. It runs single-outstanding, with independent write and read channel state machines.

---
 rtl/custom_axi_ip_regs.sv | 246 ++++++++++++++++++++++++
 tb/tb_custom_axi_ip_regs.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/custom_axi_ip_regs.sv
`default_nettype none
// ============================================================================
// Module   : custom_axi_ip_regs
// Purpose  : AXI4-Lite slave register front-end for the custom_axi_ip core.
//            Turns CPU writes into din/enable stimulus and exposes the core's
//            dout, enable_out and status_out as readable registers.
//            Single outstanding transaction per channel; independent write
//            and read state machines.
// Ports    : clk_i, rst_ni           - clock, async active-low reset
//            s_axi_aw*/w*/b*         - AXI4-Lite write channels
//            s_axi_ar*/r*            - AXI4-Lite read channels
//            din_o, enable_o         - operand and one-cycle start to core
//            dout_i, enable_i,
//            status_i                - core result, enable_out, status_out
// Map      : 0x0 CTRL (bit0 START, W1 action) | 0x4 DIN [30:0] RW
//            0x8 DOUT RO | 0xC STATUS ([1:0] status, [5:4] enable,
//            bit8 DONE_STKY W1C, bit9 START_REJ W1C)
// Revision : 1.0 - initial release
// ============================================================================
module custom_axi_ip_regs #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [30:0]           din_o,
  output logic                  enable_o,
  input  logic [DATA_WIDTH-1:0] dout_i,
  input  logic [1:0]            enable_i,
  input  logic [1:0]            status_i
);

  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;
  localparam logic [1:0] c_ST_IDLE     = 2'd0;
  localparam logic [1:0] c_ST_DONE     = 2'd2;

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  w_state_e r_wstate, w_wstate_nxt;
  r_state_e r_rstate, w_rstate_nxt;

  // Keeps the ready outputs low while reset is asserted; set by the first
  // clock edge after release.
  logic                  r_ready_en;
  logic                  r_aw_held, r_w_held;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_wstrb;
  logic [30:0]           r_din;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_enable, r_done_stky, r_start_rej;
  logic [1:0]            r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [3:0]            w_wstrb;
  logic                  w_waddr_bad, w_raddr_bad;
  logic [DATA_WIDTH-1:0] w_status, w_rd_val;
  logic                  w_unused;

  assign s_axi_awready = r_ready_en && (r_wstate == W_IDLE) && !r_aw_held;
  assign s_axi_wready  = r_ready_en && (r_wstate == W_IDLE) && !r_w_held;
  assign s_axi_bvalid  = (r_wstate == W_RESP);
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_ready_en && (r_rstate == R_IDLE);
  assign s_axi_rvalid  = (r_rstate == R_DATA);
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign din_o         = r_din;
  assign enable_o      = r_enable;

  assign w_aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_w_hs  = s_axi_wvalid && s_axi_wready;
  assign w_ar_hs = s_axi_arvalid && s_axi_arready;

  // Use the held beat if one was captured earlier, else the live bus, so a
  // commit can occur in the same cycle as either handshake.
  assign w_waddr = r_aw_held ? r_awaddr : s_axi_awaddr;
  assign w_wdata = r_w_held  ? r_wdata  : s_axi_wdata;
  assign w_wstrb = r_w_held  ? r_wstrb  : s_axi_wstrb;

  generate
    if (ADDR_WIDTH > 4) begin : g_addr_hi
      assign w_waddr_bad = |w_waddr[ADDR_WIDTH-1:4];
      assign w_raddr_bad = |s_axi_araddr[ADDR_WIDTH-1:4];
    end else begin : g_addr_lo
      assign w_waddr_bad = 1'b0;
      assign w_raddr_bad = 1'b0;
    end
  endgenerate

  // Byte offset bits and DIN bit 31 carry no information.
  assign w_unused = ^{w_waddr[1:0], s_axi_araddr[1:0], w_wdata[31]};

  assign w_status = {22'd0, r_start_rej, r_done_stky, 2'b00, enable_i, 2'b00, status_i};

  // ---------------- write channel FSM ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wstate   <= W_IDLE;
      r_rstate   <= R_IDLE;
      r_ready_en <= 1'b0;
    end else begin
      r_wstate   <= w_wstate_nxt;
      r_rstate   <= w_rstate_nxt;
      r_ready_en <= 1'b1;
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_commit     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) begin
          w_commit     = 1'b1;
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi_bready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (s_axi_rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Capture AW and W beats that arrive ahead of their partner.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else if (w_commit) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= s_axi_awaddr;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axi_wdata;
        r_wstrb  <= s_axi_wstrb;
      end
    end
  end

  // ---------------- register file ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_din       <= '0;
      r_dout      <= '0;
      r_enable    <= 1'b0;
      r_done_stky <= 1'b0;
      r_start_rej <= 1'b0;
      r_bresp     <= c_RESP_OKAY;
    end else begin
      r_enable <= 1'b0;
      r_dout   <= dout_i;
      if (w_commit) begin
        r_bresp <= w_waddr_bad ? c_RESP_SLVERR : c_RESP_OKAY;
        if (!w_waddr_bad) begin
          case (w_waddr[3:2])
            2'd0: begin
              if (w_wstrb[0] && w_wdata[0]) begin
                if (status_i == c_ST_IDLE) r_enable <= 1'b1;
                else                       r_start_rej <= 1'b1;
              end
            end
            2'd1: begin
              if (w_wstrb[0]) r_din[7:0]   <= w_wdata[7:0];
              if (w_wstrb[1]) r_din[15:8]  <= w_wdata[15:8];
              if (w_wstrb[2]) r_din[23:16] <= w_wdata[23:16];
              if (w_wstrb[3]) r_din[30:24] <= w_wdata[30:24];
            end
            2'd3: begin
              if (w_wstrb[1]) begin
                if (w_wdata[8]) r_done_stky <= 1'b0;
                if (w_wdata[9]) r_start_rej <= 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
      // Placed after the W1C so a simultaneous DONE wins over the clear.
      if (status_i == c_ST_DONE) r_done_stky <= 1'b1;
    end
  end

  // ---------------- read channel ----------------
  always_comb begin
    w_rd_val = '0;
    case (s_axi_araddr[3:2])
      2'd1:    w_rd_val = {1'b0, r_din};
      2'd2:    w_rd_val = r_dout;
      2'd3:    w_rd_val = w_status;
      default: w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdata <= '0;
      r_rresp <= c_RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rdata <= w_raddr_bad ? '0 : w_rd_val;
      r_rresp <= w_raddr_bad ? c_RESP_SLVERR : c_RESP_OKAY;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_custom_axi_ip_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_custom_axi_ip_regs
// Purpose  : Self-checking bench for custom_axi_ip_regs (ADDR_WIDTH=5).
//            Table of AXI transactions plus hand sequences for START,
//            sticky bits, backpressure, same-cycle access and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_custom_axi_ip_regs;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   wdata, rdata, dout_i;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp, enable_i, status_i;
  logic [30:0]   din_o;
  logic          enable_o;

  always #5 clk = ~clk;

  custom_axi_ip_regs #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .din_o(din_o), .enable_o(enable_o),
    .dout_i(dout_i), .enable_i(enable_i), .status_i(status_i)
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
  } rexp_t;

  logic [1:0] bq[$];
  rexp_t      rq[$];
  logic       en_commit, en_after;

  typedef struct {
    bit          wr;
    logic [AW-1:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          gap;   // <0: AW and W together, else cycles from AW to W
    logic [31:0] exp;
    logic [1:0]  resp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timeout waiting for handshake", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumers: pop expected responses when the DUT hands them over.
  logic  prev_en = 1'b0;
  logic [1:0] mb;
  rexp_t mr;
  always @(negedge clk) begin
    if (rst_n && bvalid && bready) begin
      if (bq.size() == 0) begin
        checks++; failures++;
        $display("FAIL bresp_unexpected: got 0x%0h expected none", bresp);
      end else begin
        mb = bq.pop_front();
        chk("bresp", {30'd0, bresp}, {30'd0, mb});
      end
    end
    if (rst_n && rvalid && rready) begin
      if (rq.size() == 0) begin
        checks++; failures++;
        $display("FAIL rdata_unexpected: got 0x%08h expected none", rdata);
      end else begin
        mr = rq.pop_front();
        chk("rdata", rdata, mr.d);
        chk("rresp", {30'd0, rresp}, {30'd0, mr.r});
      end
    end
    if (enable_o) chk("enable_single_cycle", prev_en, 0);
    prev_en = enable_o;
  end

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int gap, input logic [1:0] er);
    int n;
    bq.push_back(er);
    awaddr = a; wdata = d; wstrb = s;
    if (gap < 0) begin
      awvalid = 1; wvalid = 1;
      n = 0;
      while (!(awready && wready) && n < 50) begin tick(); n++; end
      if (n >= 50) timeout("aw_w_ready");
      tick();
      awvalid = 0; wvalid = 0;
    end else begin
      awvalid = 1;
      n = 0;
      while (!awready && n < 50) begin tick(); n++; end
      if (n >= 50) timeout("awready");
      tick();
      awvalid = 0;
      repeat (gap) begin
        chk("awready_after_aw", awready, 0);
        chk("no_early_bvalid", bvalid, 0);
        tick();
      end
      wvalid = 1;
      n = 0;
      while (!wready && n < 50) begin tick(); n++; end
      if (n >= 50) timeout("wready");
      tick();
      wvalid = 0;
    end
    chk("bvalid_latency", bvalid, 1);
    en_commit = enable_o;
    bready = 1;
    tick();
    bready = 0;
    en_after = enable_o;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input logic [31:0] ed, input logic [1:0] er);
    int n;
    rq.push_back('{d: ed, r: er});
    araddr = a; arvalid = 1;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    if (n >= 50) timeout("arready");
    tick();
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 50) begin tick(); n++; end
    if (n >= 50) timeout("rvalid");
    rready = 1;
    tick();
    rready = 0;
  endtask

  // Write and read handshake in the very same cycle.
  task automatic wr_rd_same(input logic [AW-1:0] wa, input logic [31:0] wd,
                            input logic [AW-1:0] ra, input logic [31:0] rexp);
    bq.push_back(2'b00);
    rq.push_back('{d: rexp, r: 2'b00});
    awaddr = wa; wdata = wd; wstrb = 4'hF; araddr = ra;
    awvalid = 1; wvalid = 1; arvalid = 1;
    chk("same_cycle_ready", awready && wready && arready, 1);
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("same_cycle_valids", bvalid && rvalid, 1);
    bready = 1; rready = 1;
    tick();
    bready = 0; rready = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0;
    dout_i = '0; enable_i = 2'b10; status_i = 2'd0;

    //                wr  addr   data          strb  gap exp           resp
    tbl.push_back('{0, 5'h00, 32'h0,        4'h0, 0,  32'h0,        2'b00});
    tbl.push_back('{0, 5'h04, 32'h0,        4'h0, 0,  32'h0,        2'b00});
    tbl.push_back('{0, 5'h08, 32'h0,        4'h0, 0,  32'h0,        2'b00});
    tbl.push_back('{0, 5'h0C, 32'h0,        4'h0, 0,  32'h20,       2'b00});
    tbl.push_back('{1, 5'h04, 32'h7FFFFFFE, 4'hF, 2,  32'h0,        2'b00});
    tbl.push_back('{0, 5'h04, 32'h0,        4'h0, 0,  32'h7FFFFFFE, 2'b00});
    tbl.push_back('{1, 5'h04, 32'hFFFFFFFF, 4'hF, -1, 32'h0,        2'b00});
    tbl.push_back('{0, 5'h04, 32'h0,        4'h0, 0,  32'h7FFFFFFF, 2'b00});
    tbl.push_back('{1, 5'h04, 32'h00000000, 4'h2, 0,  32'h0,        2'b00});
    tbl.push_back('{0, 5'h07, 32'h0,        4'h0, 0,  32'h7FFF00FF, 2'b00});
    tbl.push_back('{1, 5'h04, 32'hA5A5A5A5, 4'h9, 1,  32'h0,        2'b00});
    tbl.push_back('{0, 5'h04, 32'h0,        4'h0, 0,  32'h25FF00A5, 2'b00});
    tbl.push_back('{1, 5'h08, 32'hFFFFFFFF, 4'hF, -1, 32'h0,        2'b00});
    tbl.push_back('{0, 5'h08, 32'h0,        4'h0, 0,  32'h0,        2'b00});
    tbl.push_back('{1, 5'h00, 32'hFFFFFFFE, 4'hF, -1, 32'h0,        2'b00});
    tbl.push_back('{0, 5'h00, 32'h0,        4'h0, 0,  32'h0,        2'b00});
    tbl.push_back('{1, 5'h10, 32'hFFFFFFFF, 4'hF, -1, 32'h0,        2'b10});
    tbl.push_back('{0, 5'h10, 32'h0,        4'h0, 0,  32'h0,        2'b10});
    tbl.push_back('{1, 5'h14, 32'h00000000, 4'hF, -1, 32'h0,        2'b10});
    tbl.push_back('{0, 5'h04, 32'h0,        4'h0, 0,  32'h25FF00A5, 2'b00});
    tbl.push_back('{0, 5'h0C, 32'h0,        4'h0, 0,  32'h20,       2'b00});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_enable", enable_o, 0);
    chk("rst_din", {1'b0, din_o}, 0);
    chk("rst_rdata", rdata, 0);
    rst_n = 1;
    tick();
    chk("post_rst_ready", {29'd0, awready, wready, arready}, 32'h7);

    foreach (tbl[i]) begin
      if (tbl[i].wr) axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].gap, tbl[i].resp);
      else           axi_read(tbl[i].addr, tbl[i].exp, tbl[i].resp);
    end
    chk("din_o_after_table", {1'b0, din_o}, 32'h25FF00A5);

    // START accepted while core idle; core then runs to DONE
    status_i = 2'd0;
    axi_write(5'h00, 32'h1, 4'hF, -1, 2'b00);
    chk("start_pulse", en_commit, 1);
    chk("start_pulse_end", en_after, 0);
    dout_i = 32'h7FFFFFFF;
    status_i = 2'd1; tick(); tick();
    status_i = 2'd2; tick();
    status_i = 2'd0; tick();
    axi_read(5'h08, 32'h7FFFFFFF, 2'b00);
    axi_read(5'h0C, 32'h120, 2'b00);
    axi_write(5'h0C, 32'h100, 4'hF, -1, 2'b00);
    axi_read(5'h0C, 32'h20, 2'b00);

    // START rejected while busy
    status_i = 2'd1;
    axi_write(5'h00, 32'h1, 4'hF, 0, 2'b00);
    chk("rej_no_pulse", en_commit, 0);
    chk("rej_no_pulse_after", en_after, 0);
    axi_read(5'h0C, 32'h221, 2'b00);
    axi_write(5'h0C, 32'h200, 4'h1, -1, 2'b00);  // lane 1 not strobed
    axi_read(5'h0C, 32'h221, 2'b00);
    axi_write(5'h0C, 32'h200, 4'hF, -1, 2'b00);
    axi_read(5'h0C, 32'h21, 2'b00);

    // DONE set wins over simultaneous clear
    status_i = 2'd2;
    axi_write(5'h0C, 32'h100, 4'hF, -1, 2'b00);
    axi_read(5'h0C, 32'h122, 2'b00);
    status_i = 2'd0;
    axi_write(5'h0C, 32'h100, 4'hF, -1, 2'b00);
    axi_read(5'h0C, 32'h20, 2'b00);

    // Same-cycle read sees pre-write values
    wr_rd_same(5'h04, 32'h0BADF00D, 5'h04, 32'h25FF00A5);
    axi_read(5'h04, 32'h0BADF00D, 2'b00);
    status_i = 2'd2; tick();
    status_i = 2'd0; tick();
    wr_rd_same(5'h0C, 32'h100, 5'h0C, 32'h120);
    axi_read(5'h0C, 32'h20, 2'b00);

    // Backpressure on B and R
    bq.push_back(2'b00);
    rq.push_back('{d: 32'h11223344, r: 2'b00});
    awaddr = 5'h04; wdata = 32'h11223344; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    chk("bp_w_ready", awready && wready, 1);
    tick();
    awvalid = 0; wvalid = 0;
    araddr = 5'h04; arvalid = 1;
    chk("bp_arready", arready, 1);
    tick();
    arvalid = 0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_bvalid", bvalid, 1);
      chk("bp_bresp", {30'd0, bresp}, 0);
      chk("bp_rvalid", rvalid, 1);
      chk("bp_rdata", rdata, 32'h11223344);
      chk("bp_awready", awready, 0);
      chk("bp_arready_low", arready, 0);
      tick();
    end
    bready = 1; rready = 1;
    tick();
    bready = 0; rready = 0;
    chk("bp_release_awready", awready, 1);
    chk("bp_release_arready", arready, 1);
    chk("bp_din_o", {1'b0, din_o}, 32'h11223344);

    // Reset while a write response is pending
    awaddr = 5'h04; wdata = 32'h55; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    chk("mid_bvalid", bvalid, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_bvalid", bvalid, 0);
    chk("mid_rst_din", {1'b0, din_o}, 0);
    @(posedge clk); #1;
    rst_n = 1;
    tick();
    chk("mid_post_rst_ready", {29'd0, awready, wready, arready}, 32'h7);

    // W arriving alone must wait for its AW
    wdata = 32'h3C3C3C3C; wstrb = 4'hF; wvalid = 1;
    tick();
    wvalid = 0;
    repeat (3) begin
      chk("w_only_no_bvalid", bvalid, 0);
      chk("w_only_wready_low", wready, 0);
      tick();
    end
    bq.push_back(2'b00);
    awaddr = 5'h04; awvalid = 1;
    tick();
    awvalid = 0;
    chk("late_aw_bvalid", bvalid, 1);
    bready = 1;
    tick();
    bready = 0;
    axi_read(5'h04, 32'h3C3C3C3C, 2'b00);

    repeat (3) tick();
    chk("bq_drained", bq.size(), 0);
    chk("rq_drained", rq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
